// File: rtl/cfg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfg_seq_pkg
// Brief    : Shared types and constants for the camera configuration sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cfg_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    SEND   = 3'd3,
    DELAY  = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [15:0] CFG_END            = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY          = 16'hFFF0;
  localparam logic [7:0]  SCCB_WR_ID_DEFAULT = 8'h42;

  // Cycles in a delay entry; 64-bit so large clock/ms products cannot overflow.
  function automatic logic [63:0] delay_cycles(input logic [63:0] clk_f,
                                               input logic [63:0] delay_ms);
    return (delay_ms * clk_f) / 64'd1000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cfg_sequencer_if
// Brief    : ROM fetch port plus SCCB write request channel of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface cfg_sequencer_if;

  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_valid;
  logic        sccb_ready;
  logic [7:0]  sccb_id;
  logic [7:0]  sccb_addr;
  logic [7:0]  sccb_data;

  modport master (
    output rom_addr,
    input  rom_data,
    output sccb_valid,
    input  sccb_ready,
    output sccb_id,
    output sccb_addr,
    output sccb_data
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  sccb_valid,
    output sccb_ready,
    input  sccb_id,
    input  sccb_addr,
    input  sccb_data
  );

endinterface
`default_nettype wire

// File: rtl/cfg_delay_timer.sv
`default_nettype none
// ============================================================================
// Module   : cfg_delay_timer
// Brief    : Loadable down-counter; o_expire is high while the count is zero.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_delay_timer #(
  parameter int                CNT_W    = 1,
  parameter logic [CNT_W-1:0]  LOAD_VAL = '0
) (
  input  wire logic i_clk,
  input  wire logic i_rstn,
  input  wire logic i_load,
  output logic      o_expire
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Free-running decrement: the counter parks at zero until the next load.
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expire = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cfg_sequencer
// Brief    : Walks the config ROM and issues SCCB writes; FFF0 = delay, FFFF = end.
//            Optional SEND watchdog enabled by macro CFG_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int         CLK_F    = 25_000_000,
  parameter int         DELAY_MS = 10,
  parameter logic [7:0] SCCB_ID  = SCCB_WR_ID_DEFAULT
) (
  input  wire logic       i_clk,
  input  wire logic       i_rstn,
  input  wire logic       i_start,
  cfg_sequencer_if.master bus,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

  localparam logic [63:0] C_DELAY_CYC = delay_cycles(64'(CLK_F), 64'(DELAY_MS));
  localparam int          C_CLOG      = $clog2(C_DELAY_CYC + 64'd1);
  localparam int          C_CNT_W     = (C_CLOG < 1) ? 1 : C_CLOG;
  localparam logic [C_CNT_W-1:0] C_LOAD = C_CNT_W'(C_DELAY_CYC - 64'd1);

  state_e      state_q, state_d;
  logic [7:0]  rom_addr_q, rom_addr_d;
  logic        valid_q, valid_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        w_load;
  logic        w_expire;
  logic        w_accept;
  logic        w_last;

`ifdef CFG_SEQ_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
`endif

  assign w_load   = (state_q == DECODE) && (bus.rom_data == CFG_DELAY);
  assign w_accept = valid_q && bus.sccb_ready;
  assign w_last   = (rom_addr_q == 8'hFF);

  cfg_delay_timer #(
    .CNT_W    (C_CNT_W),
    .LOAD_VAL (C_LOAD)
  ) u_delay_timer (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_load   (w_load),
    .o_expire (w_expire)
  );

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef CFG_SEQ_TIMEOUT_EN
    wd_d       = wd_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        rom_addr_d = 8'd0;
        if (i_start) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        if (bus.rom_data == CFG_END) begin
          state_d = DONE;
        end else if (bus.rom_data == CFG_DELAY) begin
          state_d = DELAY;
        end else begin
          addr_d  = bus.rom_data[15:8];
          data_d  = bus.rom_data[7:0];
          state_d = SEND;
`ifdef CFG_SEQ_TIMEOUT_EN
          wd_d    = 16'd0;
`endif
        end
      end
      SEND: begin
        if (w_accept) begin
          // Entry 255 is the last one addressable; finish rather than wrap.
          if (w_last) begin
            state_d = DONE;
          end else begin
            rom_addr_d = rom_addr_q + 8'd1;
            state_d    = FETCH;
          end
        end
`ifdef CFG_SEQ_TIMEOUT_EN
        else if (wd_q == 16'hFFFE) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      DELAY: begin
        if (w_expire) begin
          if (w_last) begin
            state_d = DONE;
          end else begin
            rom_addr_d = rom_addr_q + 8'd1;
            state_d    = FETCH;
          end
        end
      end
      DONE: begin
        if (i_start) begin
          rom_addr_d = 8'd0;
          state_d    = FETCH;
`ifdef CFG_SEQ_TIMEOUT_EN
          err_d      = 1'b0;
`endif
        end
      end
      default: begin
        state_d    = IDLE;
        rom_addr_d = 8'd0;
      end
    endcase

    // Status outputs are registered from the next state so they line up with it.
    valid_d = (state_d == SEND);
    busy_d  = (state_d != IDLE) && (state_d != DONE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      rom_addr_q <= 8'd0;
      valid_q    <= 1'b0;
      addr_q     <= 8'd0;
      data_q     <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
      wd_q       <= 16'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef CFG_SEQ_TIMEOUT_EN
      wd_q       <= wd_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.sccb_valid = valid_q;
  assign bus.sccb_id    = SCCB_ID;
  assign bus.sccb_addr  = addr_q;
  assign bus.sccb_data  = data_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
`ifdef CFG_SEQ_TIMEOUT_EN
  assign o_err          = err_q;
`else
  assign o_err          = 1'b0;
`endif

endmodule
`default_nettype wire
